// File: rtl/serial_subtract16_pkg.sv
// Shared types and sizes for the bit-serial subtract-accumulate unit.
//   state_t : sequencer states (IDLE, SHIFT, DONE)
//   WIDTH   : operand/accumulator width (tied to the four hex digits)
//   CNT_W   : bit-counter width, $clog2(WIDTH)
package serial_sub_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtract16_if.sv
// Front-end bundle of the subtract-accumulate unit (buttons, switches, results, hex digits).
//   master : board side, drives Load_B/Run/Switches, observes results
//   slave  : datapath side, consumes controls, drives results and hex codes
//   Load_B, Run   : active-high controls
//   Switches      : subtrahend / load value
//   Difference    : committed accumulator R
//   Borrow, Ovf   : flags of the last subtraction
//   Busy, Done    : SHIFT / DONE state indicators
//   Dhex0..Dhex3  : seven-segment codes for Difference nibbles 0..3
interface serial_subtract16_if;
    import serial_sub_pkg::*;

    logic             Load_B;
    logic             Run;
    logic [WIDTH-1:0] Switches;
    logic [WIDTH-1:0] Difference;
    logic             Borrow;
    logic             Ovf;
    logic             Busy;
    logic             Done;
    logic [6:0]       Dhex0;
    logic [6:0]       Dhex1;
    logic [6:0]       Dhex2;
    logic [6:0]       Dhex3;

    modport master (
        output Load_B, Run, Switches,
        input  Difference, Borrow, Ovf, Busy, Done,
        input  Dhex0, Dhex1, Dhex2, Dhex3
    );

    modport slave (
        input  Load_B, Run, Switches,
        output Difference, Borrow, Ovf, Busy, Done,
        output Dhex0, Dhex1, Dhex2, Dhex3
    );

endinterface

// File: rtl/serial_subtract16_cells.sv
// Leaf cells of the subtract-accumulate unit.
//   full_subtractor : d = a - b - bin (one bit), bout = borrow out; combinational
//     a, b, bin (in, 1) ; d, bout (out, 1)
//   HexDriver       : 4-bit nibble to active-low seven-segment code (gfedcba)
//     In0 (in, 4) ; Out0 (out, 7)
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module HexDriver (
    input  logic [3:0] In0,
    output logic [6:0] Out0
);
    always_comb begin
        Out0 = 7'b1111111;
        unique case (In0)
            4'h0: Out0 = 7'b1000000;
            4'h1: Out0 = 7'b1111001;
            4'h2: Out0 = 7'b0100100;
            4'h3: Out0 = 7'b0110000;
            4'h4: Out0 = 7'b0011001;
            4'h5: Out0 = 7'b0010010;
            4'h6: Out0 = 7'b0000010;
            4'h7: Out0 = 7'b1111000;
            4'h8: Out0 = 7'b0000000;
            4'h9: Out0 = 7'b0010000;
            4'hA: Out0 = 7'b0001000;
            4'hB: Out0 = 7'b0000011;
            4'hC: Out0 = 7'b1000110;
            4'hD: Out0 = 7'b0100001;
            4'hE: Out0 = 7'b0000110;
            4'hF: Out0 = 7'b0001110;
            default: Out0 = 7'b1111111;
        endcase
    end
endmodule

// File: rtl/serial_subtract16.sv
// Bit-serial 16-bit subtract-accumulate: R <= R - Switches, one bit per clock, LSB first,
// through a single full-subtractor cell and a borrow flip-flop.
//   Clk   (in, 1) : rising-edge clock
//   Reset (in, 1) : asynchronous active-high reset; aborts any subtraction without commit
//   bus   (slave) : Load_B/Run/Switches in; Difference/Borrow/Ovf/Busy/Done/Dhex0..3 out
module serial_subtract16
    import serial_sub_pkg::*;
(
    input  logic                Clk,
    input  logic                Reset,
    serial_subtract16_if.slave  bus
);

    state_t           state;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] m_a;
    logic [WIDTH-1:0] s_b;
    logic [WIDTH-1:0] work;
    logic [CNT_W-1:0] cnt;
    logic             bf;
    logic             borrow_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;
    logic             d;
    logic             bout;
    logic [6:0]       hex0, hex1, hex2, hex3;

    full_subtractor u_fs (
        .a   (m_a[0]),
        .b   (s_b[0]),
        .bin (bf),
        .d   (d),
        .bout(bout)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            r        <= '0;
            m_a      <= '0;
            s_b      <= '0;
            work     <= '0;
            cnt      <= '0;
            bf       <= 1'b0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.Load_B) begin
                        r        <= bus.Switches;
                        borrow_q <= 1'b0;
                        ovf_q    <= 1'b0;
                    end else if (bus.Run) begin
                        m_a    <= r;
                        s_b    <= bus.Switches;
                        bf     <= 1'b0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    m_a  <= m_a >> 1;
                    s_b  <= s_b >> 1;
                    work <= {d, work[WIDTH-1:1]};
                    bf   <= bout;
                    cnt  <= cnt + 1'b1;
                    // Last bit: operand bit 0 now holds the original MSBs, so the
                    // overflow test uses the live a/b/d of this edge.
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        r        <= {d, work[WIDTH-1:1]};
                        borrow_q <= bout;
                        ovf_q    <= (m_a[0] ^ s_b[0]) & (m_a[0] ^ d);
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (!bus.Run) begin
                        done_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    HexDriver u_hex0 (.In0(r[3:0]),   .Out0(hex0));
    HexDriver u_hex1 (.In0(r[7:4]),   .Out0(hex1));
    HexDriver u_hex2 (.In0(r[11:8]),  .Out0(hex2));
    HexDriver u_hex3 (.In0(r[15:12]), .Out0(hex3));

    assign bus.Difference = r;
    assign bus.Borrow     = borrow_q;
    assign bus.Ovf        = ovf_q;
    assign bus.Busy       = busy_q;
    assign bus.Done       = done_q;
    assign bus.Dhex0      = hex0;
    assign bus.Dhex1      = hex1;
    assign bus.Dhex2      = hex2;
    assign bus.Dhex3      = hex3;

endmodule

// File: tb/tb_serial_subtract16.sv
// Directed bench for serial_subtract16: load/run sequences with hand-computed results,
// checked at negedges with immediate assertions.
module tb_serial_subtract16;

    logic Clk;
    logic Reset;
    int   tests;
    int   failed;
    int   busy_cycles;

    serial_subtract16_if bus ();

    serial_subtract16 dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [15:0] val);
        @(negedge Clk);
        bus.Load_B   = 1'b1;
        bus.Switches = val;
        @(negedge Clk);
        bus.Load_B   = 1'b0;
    endtask

    // Raise Run and count negedges with Busy=1 until Busy drops (bounded).
    task automatic run_and_count(input logic [15:0] sw);
        @(negedge Clk);
        bus.Run      = 1'b1;
        bus.Switches = sw;
        busy_cycles  = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (bus.Busy) busy_cycles++;
            else break;
        end
    endtask

    task automatic release_run();
        bus.Run = 1'b0;
        @(negedge Clk);
    endtask

    initial begin
        tests        = 0;
        failed       = 0;
        busy_cycles  = 0;
        Reset        = 1'b1;
        bus.Load_B   = 1'b0;
        bus.Run      = 1'b0;
        bus.Switches = 16'h0000;

        // Reset state
        repeat (2) @(negedge Clk);
        chk("rst_diff",  bus.Difference, 16'h0000);
        chk("rst_borrow", 16'(bus.Borrow), 16'h0);
        chk("rst_ovf",    16'(bus.Ovf),    16'h0);
        chk("rst_busy",   16'(bus.Busy),   16'h0);
        chk("rst_done",   16'(bus.Done),   16'h0);
        chk("rst_hex0",   16'(bus.Dhex0),  16'h0040);
        chk("rst_hex3",   16'(bus.Dhex3),  16'h0040);
        Reset = 1'b0;

        // 1: 0x0010 - 0x0003
        load(16'h0010);
        chk("t1_load", bus.Difference, 16'h0010);
        run_and_count(16'h0003);
        chk("t1_busy_cycles", 16'(busy_cycles), 16'd16);
        chk("t1_done",   16'(bus.Done),   16'h1);
        chk("t1_diff",   bus.Difference,  16'h000D);
        chk("t1_borrow", 16'(bus.Borrow), 16'h0);
        chk("t1_ovf",    16'(bus.Ovf),    16'h0);
        chk("t1_hex0",   16'(bus.Dhex0),  16'h0021);
        chk("t1_hex1",   16'(bus.Dhex1),  16'h0040);
        release_run();
        chk("t1_idle_done", 16'(bus.Done), 16'h0);

        // 2: 0x0000 - 0x0001
        load(16'h0000);
        run_and_count(16'h0001);
        chk("t2_busy_cycles", 16'(busy_cycles), 16'd16);
        chk("t2_diff",   bus.Difference,  16'hFFFF);
        chk("t2_borrow", 16'(bus.Borrow), 16'h1);
        chk("t2_ovf",    16'(bus.Ovf),    16'h0);
        chk("t2_hex0",   16'(bus.Dhex0),  16'h000E);
        chk("t2_hex1",   16'(bus.Dhex1),  16'h000E);
        chk("t2_hex2",   16'(bus.Dhex2),  16'h000E);
        chk("t2_hex3",   16'(bus.Dhex3),  16'h000E);
        release_run();

        // 3: 0x8000 - 0x0001 (signed overflow); load clears the old borrow
        load(16'h8000);
        chk("t3_load_borrow", 16'(bus.Borrow), 16'h0);
        run_and_count(16'h0001);
        chk("t3_diff",   bus.Difference,  16'h7FFF);
        chk("t3_borrow", 16'(bus.Borrow), 16'h0);
        chk("t3_ovf",    16'(bus.Ovf),    16'h1);
        release_run();

        // 4: Run held 40 cycles -> single subtraction
        load(16'h0009);
        @(negedge Clk);
        bus.Run      = 1'b1;
        bus.Switches = 16'h0002;
        repeat (40) @(negedge Clk);
        chk("t4_diff",      bus.Difference, 16'h0007);
        chk("t4_done_held", 16'(bus.Done),  16'h1);
        chk("t4_busy_held", 16'(bus.Busy),  16'h0);
        release_run();
        chk("t4_idle_done", 16'(bus.Done),  16'h0);
        repeat (3) @(negedge Clk);
        chk("t4_diff_stable", bus.Difference, 16'h0007);

        // 5: reset mid-SHIFT aborts with no commit
        load(16'h1234);
        @(negedge Clk);
        bus.Run      = 1'b1;
        bus.Switches = 16'h0001;
        repeat (9) @(posedge Clk);   // E0 then 8 shift edges
        #1;
        Reset = 1'b1;
        #1;
        chk("t5_diff_rst", bus.Difference, 16'h0000);
        chk("t5_busy_rst", 16'(bus.Busy),  16'h0);
        chk("t5_done_rst", 16'(bus.Done),  16'h0);
        @(negedge Clk);
        bus.Run = 1'b0;
        Reset   = 1'b0;
        repeat (20) @(negedge Clk);
        chk("t5_no_commit", bus.Difference, 16'h0000);
        chk("t5_busy_idle", 16'(bus.Busy),  16'h0);
        chk("t5_done_idle", 16'(bus.Done),  16'h0);

        // 6: Load_B beats Run in IDLE; Load_B and Switches ignored during SHIFT
        @(negedge Clk);
        bus.Load_B   = 1'b1;
        bus.Run      = 1'b1;
        bus.Switches = 16'h00AA;
        @(negedge Clk);
        chk("t6_load_wins", bus.Difference, 16'h00AA);
        chk("t6_no_busy",   16'(bus.Busy),  16'h0);
        @(negedge Clk);
        chk("t6_no_busy2",  16'(bus.Busy),  16'h0);
        bus.Load_B = 1'b0;
        bus.Run    = 1'b0;
        @(negedge Clk);
        bus.Run      = 1'b1;
        bus.Switches = 16'h0002;
        @(negedge Clk);
        chk("t6_busy_start", 16'(bus.Busy), 16'h1);
        bus.Load_B   = 1'b1;
        bus.Switches = 16'hFFFF;
        busy_cycles  = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (bus.Busy) busy_cycles++;
            else break;
        end
        chk("t6_busy_cycles", 16'(busy_cycles), 16'd16);
        chk("t6_diff",        bus.Difference,   16'h00A8);
        chk("t6_done",        16'(bus.Done),    16'h1);
        bus.Load_B = 1'b0;
        bus.Run    = 1'b0;
        @(negedge Clk);
        chk("t6_final_diff", bus.Difference, 16'h00A8);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
